// File: rtl/handshake_pkg.sv
// Shared types and helpers for the request/response handshake responder and its monitor.
// Response relation and throttle LFSR step live here so both sides compute them identically.
package handshake_pkg;

  localparam int DATA_W = 4;
  localparam int MAX_W = 32;
  // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting Fibonacci register (bits 7,5,4,3).
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              tag;
  } req_entry_t;

  // Reduction over only the low 'width' bits, so one function serves any payload width.
  function automatic logic resp_fn(input logic [MAX_W-1:0] data, input int width, input logic tag);
    logic any_set;
    logic all_set;
    any_set = 1'b0;
    all_set = 1'b1;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) begin
        any_set = any_set | data[i];
        all_set = all_set & data[i];
      end
    end
    return any_set & (all_set & tag);
  endfunction

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/handshake_responder_rsp_fifo.sv
// Synchronous FIFO holding accepted requests; head is read straight from the storage array.
// Latency: a push is visible at the head the cycle after the write edge.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic                     CLK,
  input  logic                     ASYNCRESETN,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Pointers carry one extra MSB so equal low bits can be told apart as full vs empty.
  assign count   = wr_ptr - rd_ptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (wr_ptr == rd_ptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/handshake_responder.sv
// Ready-driving responder: buffers ready/valid requests and returns one response bit per request.
// Latency: request accepted at edge N is presented as a response from cycle N+1.
// Backpressure: registered req_ready drops on full or LFSR stall; responses hold while resp_ready=0.
module handshake_responder
  import handshake_pkg::*;
#(
  parameter int         WIDTH     = DATA_W,
  parameter int         DEPTH     = 4,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                      CLK,
  input  logic                      ASYNCRESETN,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [WIDTH-1:0]          req_data,
  input  logic                      req_tag,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic                      resp_out,
  output logic [WIDTH-1:0]          resp_data,
  input  logic                      throttle_en,
  input  logic [2:0]                stall_thresh,
  output logic [$clog2(DEPTH):0]    occupancy,
  output logic [15:0]               req_count,
  output logic [15:0]               resp_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH:0]  head;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_next;
  logic            push;
  logic            pop;
  logic [7:0]      lfsr;
  logic [7:0]      lfsr_next;
  logic            full_next;
  logic            stall_next;

  assign push = req_valid & req_ready;
  assign pop  = resp_valid & resp_ready;

  rsp_fifo #(
    .DEPTH (DEPTH),
    .W     (WIDTH + 1)
  ) u_rsp_fifo (
    .CLK         (CLK),
    .ASYNCRESETN (ASYNCRESETN),
    .push        (push),
    .pop         (pop),
    .din         ({req_data, req_tag}),
    .dout        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (count)
  );

  // Ready looks one cycle ahead: it accounts for this cycle's push and pop and the next LFSR state.
  assign count_next = count + CW'(push) - CW'(pop);
  assign full_next  = (count_next == CW'(DEPTH));
  assign lfsr_next  = lfsr_step(lfsr);
  assign stall_next = throttle_en & (lfsr_next[2:0] < stall_thresh);

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      lfsr       <= LFSR_SEED;
      req_ready  <= 1'b0;
      req_count  <= '0;
      resp_count <= '0;
    end else begin
      lfsr      <= lfsr_next;
      req_ready <= ~full_next & ~stall_next;
      if (push) req_count  <= req_count + 16'd1;
      if (pop)  resp_count <= resp_count + 16'd1;
    end
  end

  // Outputs are forced to zero when empty rather than showing a stale storage slot.
  assign occupancy  = count;
  assign resp_valid = ~fifo_empty;
  assign resp_data  = fifo_empty ? '0 : head[WIDTH:1];
  assign resp_out   = ~fifo_empty & resp_fn(MAX_W'(head[WIDTH:1]), WIDTH, head[0]);

  // Full implies no push was possible this cycle; the storage also refuses it.
  logic unused_full;
  assign unused_full = fifo_full;

endmodule
